ysyx_22041752_mem_arb: RTL

Two-master arbiter that shares the single memory port between the instruction-fetch requester (IFU) and the data requester (EXU `data_*` port). It sequences each access through a request/grant/response handshake toward memory. It gives the data side priority, with a starvation guard for fetch, and discards fetch responses that a pipeline flush has made stale. It sits between IFU/EXU and the memory/bus bridge.

---
 rtl/ysyx_22041752_mem_arb_if.sv | 39 +++
 rtl/ysyx_22041752_mem_arb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_mem_arb_if.sv
// Request/response bundle between the IFU/EXU requesters, the arbiter and the
// memory port. The arbiter takes the slave view; requesters and memory take master.
interface ysyx_22041752_mem_arb_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic              inst_en;
  logic [AW-1:0]     inst_addr;
  logic              inst_ready;
  logic [DW-1:0]     inst_rdata;
  logic              data_en;
  logic [DW/8-1:0]   data_wen;
  logic [AW-1:0]     data_addr;
  logic [DW-1:0]     data_wdata;
  logic              data_ready;
  logic [DW-1:0]     data_rdata;
  logic              flush;
  logic              mem_req;
  logic [DW/8-1:0]   mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata, flush,
           mem_gnt, mem_rvalid, mem_rdata,
    output inst_ready, inst_rdata, data_ready, data_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata, flush,
           mem_gnt, mem_rvalid, mem_rdata,
    input  inst_ready, inst_rdata, data_ready, data_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ysyx_22041752_mem_arb.sv
// Fetch/data arbiter onto one memory port: data wins, fetch is guarded against
// starvation, flushed fetch responses are swallowed. Perf counters: YSYX_22041752_ARB_PERF_EN.
module ysyx_22041752_mem_arb #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  ysyx_22041752_mem_arb_if.slave bus
`ifdef YSYX_22041752_ARB_PERF_EN
  ,
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_data_cnt,
  output logic [31:0] perf_conflict_cnt
`endif
);

  localparam int            SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam int            WW         = DW / 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} own_e;

  state_e          state_q, state_d;
  own_e            own_q, own_d;
  logic            drop_q, drop_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            req_q, req_d;
  logic [WW-1:0]   wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            gnt_d_s, gnt_i_s;
  logic            inst_ready_s, data_ready_s;
  logic [DW-1:0]   inst_rdata_s, data_rdata_s;

  // State and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      own_q    <= OWN_D;
      drop_q   <= 1'b0;
      starve_q <= {SW{1'b0}};
      req_q    <= 1'b0;
      wen_q    <= {WW{1'b0}};
      addr_q   <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      req_q    <= req_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Fetch only wins a contended IDLE once data has been granted STARVE_MAX times in a row.
  assign gnt_d_s = bus.data_en && (!bus.inst_en || (starve_q < STARVE_LIM));
  assign gnt_i_s = !gnt_d_s && bus.inst_en && !bus.flush;

  // Next-state logic and response steering.
  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    drop_d       = drop_q;
    starve_d     = starve_q;
    req_d        = req_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_ready_s = 1'b0;
    inst_rdata_s = {DW{1'b0}};
    data_ready_s = 1'b0;
    data_rdata_s = {DW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (gnt_d_s) begin
          own_d    = OWN_D;
          addr_d   = bus.data_addr;
          wen_d    = bus.data_wen;
          wdata_d  = bus.data_wdata;
          starve_d = bus.inst_en ? (starve_q + SW'(1)) : {SW{1'b0}};
          drop_d   = 1'b0;
          req_d    = 1'b1;
          state_d  = S_REQ;
        end else if (gnt_i_s) begin
          own_d    = OWN_I;
          addr_d   = bus.inst_addr;
          wen_d    = {WW{1'b0}};
          wdata_d  = {DW{1'b0}};
          starve_d = {SW{1'b0}};
          drop_d   = 1'b0;
          req_d    = 1'b1;
          state_d  = S_REQ;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_REQ: begin
        if ((own_q == OWN_I) && bus.flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (bus.mem_gnt) begin
          req_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if ((own_q == OWN_I) && bus.flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (bus.mem_rvalid) begin
          // A flush in the response cycle itself must also kill delivery.
          if (own_q == OWN_D) begin
            data_ready_s = 1'b1;
            data_rdata_s = bus.mem_rdata;
          end else if (!drop_q && !bus.flush) begin
            inst_ready_s = 1'b1;
            inst_rdata_s = bus.mem_rdata;
          end else begin
            inst_ready_s = 1'b0;
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_req    = req_q;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.inst_ready = inst_ready_s;
  assign bus.inst_rdata = inst_rdata_s;
  assign bus.data_ready = data_ready_s;
  assign bus.data_rdata = data_rdata_s;

`ifdef YSYX_22041752_ARB_PERF_EN
  logic [31:0] perf_inst_q, perf_data_q, perf_conf_q;

  // Event counters, free-running and wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_inst_q <= 32'd0;
      perf_data_q <= 32'd0;
      perf_conf_q <= 32'd0;
    end else begin
      perf_inst_q <= inst_ready_s ? (perf_inst_q + 32'd1) : perf_inst_q;
      perf_data_q <= data_ready_s ? (perf_data_q + 32'd1) : perf_data_q;
      perf_conf_q <= ((state_q == S_IDLE) && bus.inst_en && bus.data_en)
                     ? (perf_conf_q + 32'd1) : perf_conf_q;
    end
  end

  assign perf_inst_cnt     = perf_inst_q;
  assign perf_data_cnt     = perf_data_q;
  assign perf_conflict_cnt = perf_conf_q;
`endif

endmodule
